// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one saturating signed adder among N requesters,
// with a single registered result slot. Optional macro: ADDER_RR_ARBITER_SATCOUNT_EN.
module adder_rr_arbiter #(
  parameter int P   = 8,
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N*P-1:0]   req_a,
  input  logic [N*P-1:0]   req_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P-1:0]     out_sum,
  output logic [IDW-1:0]   out_id,
  output logic             out_sat,
  output logic [15:0]      sat_count
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           valid_q;
  logic [P-1:0]   sum_q;
  logic [IDW-1:0] id_q;
  logic           sat_q;

  logic           slot_free;
  logic           found;
  logic           accept;
  logic [IDW-1:0] winner;
  logic [P-1:0]   a_sel, b_sel;
  logic [P:0]     sum_full;
  logic [P-1:0]   sum_sat;
  logic           sat_flag;

  assign slot_free = !valid_q || out_ready;

  // Rotating priority search: first valid request at or after the pointer.
  always_comb begin
    int unsigned idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // Gated by rst_n so no grant is advertised while reset is held.
  assign accept = found && slot_free && rst_n;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_comb begin
    a_sel    = req_a[int'(winner)*P +: P];
    b_sel    = req_b[int'(winner)*P +: P];
    sum_full = {a_sel[P-1], a_sel} + {b_sel[P-1], b_sel};
    sat_flag = sum_full[P] != sum_full[P-1];
    if (sat_flag)
      sum_sat = sum_full[P] ? {1'b1, {(P-1){1'b0}}} : {1'b0, {(P-1){1'b1}}};
    else
      sum_sat = sum_full[P-1:0];
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (winner == IDW'(N-1)) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      id_q    <= '0;
      sat_q   <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (accept) begin
        valid_q <= 1'b1;
        sum_q   <= sum_sat;
        id_q    <= winner;
        sat_q   <= sat_flag;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_id    = id_q;
  assign out_sat   = sat_q;

`ifdef ADDER_RR_ARBITER_SATCOUNT_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_cnt_q <= '0;
    else if (accept && sat_flag && (sat_cnt_q != '1))
      sat_cnt_q <= sat_cnt_q + 16'd1;
  end

  assign sat_count = sat_cnt_q;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Self-checking bench for adder_rr_arbiter: vector table, directed corner sequences,
// and randomized traffic against a behavioural model of the arbitration rules.
module tb_adder_rr_arbiter;
  localparam int P = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*P-1:0] req_a, req_b;
  logic           out_valid;
  logic           out_ready;
  logic [P-1:0]   out_sum;
  logic [1:0]     out_id;
  logic           out_sat;
  logic [15:0]    sat_count;

  adder_rr_arbiter #(.P(P), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_id(out_id), .out_sat(out_sat),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  bit         m_valid;
  logic [7:0] m_sum;
  int         m_id;
  bit         m_sat;
  int         m_ptr;
  int         m_satcnt;
  int         last_acc;
  logic [3:0] pre_rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_sum = '0; m_id = 0; m_sat = 0; m_ptr = 0; m_satcnt = 0; last_acc = -1;
  endtask

  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int expected_satcount();
`ifdef ADDER_RR_ARBITER_SATCOUNT_EN
    return m_satcnt;
`else
    return 0;
`endif
  endfunction

  // One clock: check grant before the edge, advance the model, check outputs after.
  task automatic cycle();
    int g, s;
    bit free;
    logic [3:0] er;
    #1;
    g = pick(req_valid, m_ptr);
    free = !m_valid || out_ready;
    er = '0;
    if (g >= 0 && free) er[g] = 1'b1;
    pre_rdy = req_ready;
    chk("req_ready", 32'(req_ready), 32'(er));
    last_acc = -1;
    if (g >= 0 && free) begin
      s = int'($signed(req_a[g*P +: P])) + int'($signed(req_b[g*P +: P]));
      m_sat = (s > 127) || (s < -128);
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      m_sum = 8'(s);
      m_id = g;
      m_valid = 1;
      m_ptr = (g + 1) % N;
      if (m_sat && m_satcnt < 65535) m_satcnt++;
      last_acc = g;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_sum", 32'(out_sum), 32'(m_sum));
      chk("out_id", 32'(out_id), 32'(m_id));
      chk("out_sat", 32'(out_sat), 32'(m_sat));
    end
    chk("sat_count", 32'(sat_count), 32'(expected_satcount()));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] a;
    logic [31:0] b;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ovld;
    logic [7:0]  sum;
    logic [1:0]  id;
    logic        sat;
  } vec_t;

  vec_t tbl[7];
  int   rr_ids[6];
  logic [7:0] sa[8], sb[8];

  initial begin
    logic [7:0] s0;
    logic [1:0] i0;

    tbl[0] = '{4'b0001, 32'h0000_0001, 32'h0000_0002, 1'b1, 4'b0001, 1'b1, 8'd3,   2'd0, 1'b0};
    tbl[1] = '{4'b0100, 32'h007C_0000, 32'h0004_0000, 1'b1, 4'b0100, 1'b1, 8'h7F,  2'd2, 1'b1};
    tbl[2] = '{4'b0100, 32'h0081_0000, 32'h00FE_0000, 1'b1, 4'b0100, 1'b1, 8'h80,  2'd2, 1'b1};
    tbl[3] = '{4'b0100, 32'h0008_0000, 32'h00F8_0000, 1'b1, 4'b0100, 1'b1, 8'h00,  2'd2, 1'b0};
    tbl[4] = '{4'b1001, 32'h0A00_0000, 32'h1400_0000, 1'b1, 4'b1000, 1'b1, 8'd30,  2'd3, 1'b0};
    tbl[5] = '{4'b1001, 32'h0000_00FB, 32'h0000_00FA, 1'b1, 4'b0001, 1'b1, 8'hF5,  2'd0, 1'b0};
    tbl[6] = '{4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00,  2'd0, 1'b0};
    rr_ids = '{0, 1, 2, 3, 0, 1};
    sa = '{8'd100, 8'd1, 8'h9C, 8'd127, 8'hFF, 8'h80, 8'd50, 8'd127};
    sb = '{8'd100, 8'd1, 8'h9C, 8'd1,   8'hFF, 8'hFF, 8'd50, 8'd127};

    req_valid = '0; req_a = '0; req_b = '0; out_ready = 1'b0;
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      req_valid = tbl[i].v; req_a = tbl[i].a; req_b = tbl[i].b; out_ready = tbl[i].ordy;
      cycle();
      chk("tbl_rdy", 32'(pre_rdy), 32'(tbl[i].rdy));
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].ovld));
      if (tbl[i].ovld) begin
        chk("tbl_sum", 32'(out_sum), 32'(tbl[i].sum));
        chk("tbl_id", 32'(out_id), 32'(tbl[i].id));
        chk("tbl_sat", 32'(out_sat), 32'(tbl[i].sat));
      end
    end

    // Asynchronous reset with a held result
    req_valid = 4'b0001; req_a = 32'd5; req_b = 32'd5; out_ready = 1'b1;
    cycle();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_sum", 32'(out_sum), 32'd0);
    chk("async_rst_ready", 32'(req_ready), 32'd0);
    chk("async_rst_id", 32'(out_id), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin with all requesters asserted
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[i*P +: P] = 8'(i);
      req_b[i*P +: P] = 8'd1;
    end
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_id", 32'(out_id), 32'(rr_ids[k]));
      chk("rr_valid", 32'(out_valid), 32'd1);
    end

    // Backpressure: slot held, nothing granted, then release grants next in order
    s0 = out_sum; i0 = out_id;
    req_valid = 4'b0110; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_rdy", 32'(pre_rdy), 32'd0);
      chk("bp_sum_hold", 32'(out_sum), 32'(s0));
      chk("bp_id_hold", 32'(out_id), 32'(i0));
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_release_rdy", 32'(pre_rdy), 32'b0100);
    chk("bp_release_id", 32'(out_id), 32'd2);
    chk("bp_release_sum", 32'(out_sum), 32'd3);
    chk("bp_release_valid", 32'(out_valid), 32'd1);

    // Saturation counter: 5 saturating accepts among 8
    req_valid = '0;
    do_reset();
    req_valid = 4'b0001; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_a[7:0] = sa[k]; req_b[7:0] = sb[k];
      cycle();
    end
`ifdef ADDER_RR_ARBITER_SATCOUNT_EN
    chk("satcount_total", 32'(sat_count), 32'd5);
`else
    chk("satcount_total", 32'(sat_count), 32'd0);
`endif

    // Randomized traffic; a pending request keeps its operands until accepted
    req_valid = '0;
    last_acc = -1;
    for (int c = 0; c < 500; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && i != last_acc) continue;
        req_valid[i] = $urandom_range(0, 1) != 0;
        if (req_valid[i]) begin
          req_a[i*P +: P] = 8'($urandom);
          req_b[i*P +: P] = 8'($urandom);
        end
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one P-bit saturating signed adder (existing `bitwise_add`) among N requesters.
- Round-robin arbitration, valid/ready handshake on each request port, single registered output slot with its own valid/ready.
- Sits between the systolic-array partial-sum producers and the downstream accumulator/writeback stage.
- Lets several producers time-multiplex one adder instead of instantiating one adder each.

Parameters:
- P, 8: operand and result width in bits, signed two's complement.
- N, 4: number of requesters, N >= 1.
- IDW, max(1, $clog2(N)): width of the requester ID.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N  per-requester request valid.
- req_ready  out  N  per-requester grant/accept, one-hot or zero.
- req_a  in  N*P  packed operand A; slice i is [i*P +: P].
- req_b  in  N*P  packed operand B; same packing as req_a.
- out_valid  out  1  result slot holds valid data.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  P  saturated sum.
- out_id  out  IDW  index of the requester that produced out_sum.
- out_sat  out  1  high if out_sum was clamped.
- sat_count  out  16  saturation event counter (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_sum=0, out_id=0, out_sat=0, rr pointer=0, sat_count=0, req_ready=0.
- A reset mid-operation discards any held result immediately.
- slot_free = !out_valid || out_ready.
- Grant logic is combinational:
  - Search req_valid starting at the rr pointer, ascending with wrap N-1 -> 0.
  - The first asserted request wins.
  - req_ready[i] = slot_free && (winner == i).
  - At most one req_ready bit is high per cycle; all are 0 when no request is valid or the slot is not free.
- Accept (req_valid[i] && req_ready[i]) at edge k:
  - out_sum = sat(a_i + b_i), out_id = i, out_sat = clamp flag, out_valid = 1, all visible after edge k.
  - Latency is exactly 1 cycle.
  - rr pointer becomes (i+1) mod N.
- Arithmetic:
  - Compute the P+1-bit sum.
  - If it exceeds 2^(P-1)-1, output 2^(P-1)-1 with out_sat=1.
  - If it is below -2^(P-1), output -2^(P-1) with out_sat=1.
  - Otherwise output the exact sum with out_sat=0.
- Drain: out_valid && out_ready with no accept in the same cycle -> out_valid=0 next cycle. out_sum/out_id/out_sat hold their last value (don't-care).
- Simultaneous drain and accept: the slot is overwritten with the new result, out_valid stays 1. Sustained throughput is 1 result/cycle.
- Backpressure: out_valid && !out_ready -> all req_ready=0; out_sum, out_id and out_sat are held stable.
- rr pointer changes only on an accept. Idle cycles and stalled cycles do not move it.
- Requester obligations (checked by the bench):
  - Once req_valid[i] is raised, it stays high until accepted.
  - req_a/req_b slice i stays stable until accepted.
- N=1: the arbiter degenerates to a registered adder with handshake; out_id is always 0.

Optional Feature:
- Macro: ADDER_RR_ARBITER_SATCOUNT_EN.
- Defined:
  - sat_count increments by 1 on every accept whose result saturates.
  - It sticks at 16'hFFFF and does not wrap.
  - It is cleared only by rst_n.
- Not defined: sat_count is tied to 16'h0000 and no counter flops are synthesised. The port list is unchanged.

Test Plan:
- Reset: with out_valid=1, assert rst_n=0 between clock edges -> out_valid=0, out_sum=0, req_ready=0 immediately, before the next edge.
- Single request: P=8, N=4; req_valid=4'b0001, a=1, b=2, out_ready=1 -> req_ready=4'b0001 that cycle; next cycle out_valid=1, out_sum=3, out_id=0, out_sat=0.
- Saturation via requester 2:
  - a=124, b=4 -> out_sum=127, out_sat=1.
  - a=-127, b=-2 -> out_sum=-128, out_sat=1.
  - a=8, b=-8 -> out_sum=0, out_sat=0.
- Round-robin: req_valid=4'b1111 held, out_ready=1 -> accepts on consecutive cycles with ids 0,1,2,3,0,1, one result per cycle. After a grant to 2 with only req 0 and 3 valid -> next grant goes to 3, then 0.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with req_valid=4'b0110 -> req_ready=0 and out_sum/out_id unchanged for all 3 cycles. Raise out_ready -> the same cycle grants the next requester in rr order; the new result appears next cycle with out_valid continuously 1.
- Saturation counter, macro defined: 5 saturating accepts interleaved with 3 non-saturating ones -> sat_count=5. Macro undefined, same stimulus -> sat_count=0.
